// File: rtl/mem_tile_writer.sv
// Streams an N x N tile into port A of the matrix buffer, row-major or transposed,
// relative to a base address. Flags malformed s_last framing and pulses done when finished.
module mem_tile_writer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int N     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clkA,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic             transpose,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             enA,
  output logic             weA,
  output logic [AW-1:0]    addrA,
  output logic [WIDTH-1:0] dinA
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    r_q, r_d, c_q, c_d;
  logic [AW-1:0]    base_q, base_d;
  logic             tr_q, tr_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s_ready_q, s_ready_d;
  logic             en_q, en_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d;

  logic             beat;
  logic             last_beat;
  logic [AW-1:0]    off_row, off_col;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    base_d    = base_q;
    tr_d      = tr_q;
    err_d     = err_q;
    en_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;

    beat      = (state_q == LOAD) && s_valid && s_ready_q;
    last_beat = (r_q == CW'(N - 1)) && (c_q == CW'(N - 1));
    // Offsets never exceed N*N-1, so only the base sum can wrap.
    off_row   = AW'(r_q) * AW'(N) + AW'(c_q);
    off_col   = AW'(c_q) * AW'(N) + AW'(r_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base;
          tr_d    = transpose;
          r_d     = '0;
          c_d     = '0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (beat) begin
          en_d   = 1'b1;
          addr_d = base_q + (tr_q ? off_col : off_row);
          din_d  = s_data;
          if (c_q == CW'(N - 1)) begin
            c_d = '0;
            r_d = r_q + CW'(1);
          end else begin
            c_d = c_q + CW'(1);
          end
          if (last_beat || s_last) state_d = FLUSH;
          // Early s_last or a missing one on the final beat both mean bad framing.
          if (last_beat != s_last) err_d = 1'b1;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    s_ready_d = (state_d == LOAD);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clkA) begin
    if (rst) begin
      state_q   <= IDLE;
      r_q       <= '0;
      c_q       <= '0;
      base_q    <= '0;
      tr_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_ready_q <= 1'b0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      base_q    <= base_d;
      tr_q      <= tr_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_ready_q <= s_ready_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign s_ready = s_ready_q;
  assign enA     = en_q;
  assign weA     = en_q;
  assign addrA   = addr_q;
  assign dinA    = din_q;

endmodule

// File: tb/tb_mem_tile_writer.sv
// Directed bench for mem_tile_writer with N=4, DEPTH=32: ordering, wrap, framing errors,
// s_valid gaps, ignored start and mid-tile reset, against a bench-side buffer model.
module tb_mem_tile_writer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int N     = 4;
  localparam int AW    = 5;

  logic             clkA = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base_i = '0;
  logic             transpose = 1'b0;
  logic             s_valid = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic             busy, done, err, s_ready, enA, weA;
  logic [AW-1:0]    addrA;
  logic [WIDTH-1:0] dinA;

  mem_tile_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N(N)) dut (
    .clkA(clkA), .rst(rst), .start(start), .base(base_i), .transpose(transpose),
    .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA)
  );

  always #5 clkA = ~clkA;

  int cyc = 0;
  always @(posedge clkA) cyc <= cyc + 1;

  typedef struct {int a; int d; int cyc;} wr_t;
  wr_t              wq[$];
  int               acc_q[$];
  logic [WIDTH-1:0] mem [DEPTH];
  int               done_cnt = 0;
  int               done_cyc = -1;
  int               errors = 0;
  int               checks = 0;

  // Bench-side buffer: a write presented in a cycle commits at the end of it.
  always @(negedge clkA) begin
    checks++;
    assert (enA === weA) else begin
      errors++;
      $error("FAIL en_we_equal observed enA=%b weA=%b", enA, weA);
    end
    if (enA === 1'b1 && weA === 1'b1) begin
      mem[addrA] = dinA;
      wq.push_back('{int'(addrA), int'(dinA), cyc});
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clkA);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int b, input logic tr, output int t_start);
    wq.delete();
    acc_q.delete();
    start = 1'b1;
    base_i = AW'(b);
    transpose = tr;
    t_start = cyc;
    tick;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", s_ready, 1);
    chk("start_err_clear", err, 0);
  endtask

  task automatic send_beat(input int d, input logic last, output int t_acc);
    int budget;
    budget = 0;
    s_valid = 1'b1;
    s_data = WIDTH'(d);
    s_last = last;
    while (s_ready !== 1'b1 && budget < 20) begin
      tick;
      budget++;
    end
    chk("beat_accept", s_ready, 1);
    t_acc = cyc;
    acc_q.push_back(cyc);
    tick;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  // Entered one cycle after the final accept (the FLUSH cycle).
  task automatic finish_tile(input int t_last, input logic exp_err);
    chk("flush_ready", s_ready, 0);
    chk("flush_write", enA, 1);
    chk("flush_busy", busy, 1);
    chk("flush_done", done, 0);
    chk("flush_err", err, exp_err);
    tick;
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_err", err, exp_err);
    tick;
    chk("done_end", done, 0);
    chk("busy_fall", busy, 0);
    chk("err_sticky", err, exp_err);
    chk("done_cycle", done_cyc, t_last + 2);
  endtask

  task automatic check_writes(input string tag, input int b, input logic tr, input int d0, input int n);
    int r, c, ea;
    chk({tag, "_nwrites"}, wq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wq.size() && i < acc_q.size()) begin
        r  = i / N;
        c  = i % N;
        ea = (b + (tr ? c * N + r : r * N + c)) % DEPTH;
        chk($sformatf("%s_addr%0d", tag, i), wq[i].a, ea);
        chk($sformatf("%s_data%0d", tag, i), wq[i].d, d0 + i);
        chk($sformatf("%s_wcyc%0d", tag, i), wq[i].cyc, acc_q[i] + 1);
      end
    end
  endtask

  initial begin
    int t_start, t_last, pre_done;

    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_enA", enA, 0);
    chk("rst_weA", weA, 0);
    chk("rst_addrA", addrA, 0);
    chk("rst_dinA", dinA, 0);
    rst = 1'b0;
    tick;
    chk("idle_busy", busy, 0);
    chk("idle_ready", s_ready, 0);

    // Row-major, back-to-back, correct framing.
    do_start(0, 1'b0, t_start);
    for (int k = 0; k < 16; k++) send_beat(k + 1, k == 15, t_last);
    finish_tile(t_last, 1'b0);
    chk("t1_min_tile_time", done_cyc - t_start, N * N + 2);
    check_writes("t1", 0, 1'b0, 1, 16);

    // Transposed placement.
    do_start(0, 1'b1, t_start);
    for (int k = 0; k < 16; k++) send_beat(k + 1, k == 15, t_last);
    finish_tile(t_last, 1'b0);
    check_writes("t2", 0, 1'b1, 1, 16);
    chk("t2_readback_w1", mem[1], 5);
    chk("t2_readback_w4", mem[4], 2);

    // Address wrap from base 28.
    do_start(28, 1'b0, t_start);
    for (int k = 0; k < 16; k++) send_beat(100 + k, k == 15, t_last);
    finish_tile(t_last, 1'b0);
    check_writes("t3", 28, 1'b0, 100, 16);
    chk("t3_wrap_addr4", wq.size() > 4 ? wq[4].a : -1, 0);

    // Early s_last on k=5; a start during FLUSH must be ignored.
    do_start(4, 1'b0, t_start);
    for (int k = 0; k < 6; k++) send_beat(50 + k, k == 5, t_last);
    start = 1'b1;
    base_i = 5'd9;
    transpose = 1'b1;
    finish_tile(t_last, 1'b1);
    check_writes("t4", 4, 1'b0, 50, 6);
    tick;
    chk("t4_no_restart", busy, 0);

    // Missing s_last on the final beat, with random s_valid gaps.
    do_start(8, 1'b0, t_start);
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 2)) tick;
      send_beat(200 + k, 1'b0, t_last);
    end
    finish_tile(t_last, 1'b1);
    check_writes("t5", 8, 1'b0, 200, 16);

    // Start during LOAD is ignored; reset after 7 beats abandons the tile.
    do_start(16, 1'b0, t_start);
    pre_done = done_cnt;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin
        start = 1'b1;
        base_i = 5'd0;
        transpose = 1'b1;
      end
      send_beat(300 + k, 1'b0, t_last);
      start = 1'b0;
      chk("t6_err_unchanged", err, 0);
    end
    rst = 1'b1;
    tick;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_ready", s_ready, 0);
    chk("t6_rst_enA", enA, 0);
    chk("t6_rst_weA", weA, 0);
    chk("t6_rst_addrA", addrA, 0);
    chk("t6_rst_dinA", dinA, 0);
    rst = 1'b0;
    repeat (5) tick;
    chk("t6_idle_busy", busy, 0);
    chk("t6_no_done", done_cnt, pre_done);
    check_writes("t6", 16, 1'b0, 300, 7);
    for (int k = 0; k < 7; k++) chk($sformatf("t6_kept%0d", k), mem[16 + k], 300 + k);
    chk("t6_untouched_w23", mem[23], 215);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_tile_writer.md
# mem_tile_writer

Write-side loader for the dual-port matrix buffer in the matrix-multiply datapath. Accepts an N×N tile of elements from a valid/ready stream and drives the buffer's port-A write interface (enA/weA/addrA/dinA), placing each element at a base-relative address in row-major or transposed order. Reports completion with a one-cycle `done` pulse and flags tiles whose `s_last` framing is malformed.

## Interface
- `WIDTH`, 32, element/data width (matches buffer width)
- `DEPTH`, 512, buffer depth in words; `AW = $clog2(DEPTH)`
- `N`, 16, tile dimension; tile size is N*N elements, with N*N ≤ DEPTH

- `clkA`  in  1  write-side clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-high; clock clkA
- `start`  in  1  single-cycle request to load one tile; ignored unless IDLE
- `base`  in  AW  tile base address; sampled on accepted `start`
- `transpose`  in  1  0 = row-major, 1 = column-major placement; sampled on accepted `start`
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse when tile writes are complete
- `err`  out  1  sticky framing error; cleared on the next accepted `start`
- `s_valid`  in  1  stream element valid
- `s_ready`  out  1  stream ready; high only in LOAD
- `s_data`  in  WIDTH  stream element
- `s_last`  in  1  marks the final element of the tile
- `enA`, `weA`  out  1  buffer port-A enable and write enable; always driven equal
- `addrA`  out  AW  buffer write address
- `dinA`  out  WIDTH  buffer write data

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: on `start`, latch `base` and `transpose`, clear row counter `r`, column counter `c`, beat count `k`, and `err`, then go to LOAD.
- LOAD: `s_ready`=1. A beat is accepted when `s_valid && s_ready`. Each accepted beat is element (r,c), with `k = r*N + c`.
  - Row-major address: `base + r*N + c`.
  - Transposed address: `base + c*N + r`.
  - Address sums are truncated to AW bits, so addresses wrap modulo DEPTH.
- Counter advance per beat: `c` increments; when `c == N-1`, `c` returns to 0 and `r` increments.
- Framing rules:
  - `s_last=1` on beat k < N*N-1: set `err` and go to FLUSH. The tile ends early; remaining locations are unwritten.
  - Beat k = N*N-1 with `s_last=0`: set `err` and go to FLUSH.
  - Beat k = N*N-1 with `s_last=1`: go to FLUSH, no error.
- FLUSH: `s_ready`=0. The final write is presented on the port this cycle. Next state is DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` while not IDLE is ignored entirely: no relatch, `err` unchanged.
- Reset in any state: go to IDLE immediately. Words already written stay in the buffer; the partial tile is abandoned and `done` is not pulsed.

## Timing
- Write outputs are registered. A beat accepted in cycle t drives `enA=weA=1` with its `addrA`/`dinA` in cycle t+1, and the buffer commits it at the end of t+1.
- When no beat was accepted in cycle t, `enA=weA=0` in t+1. `addrA`/`dinA` hold their last values.
- Throughput is one element per cycle while `s_valid` stays high. Gaps in `s_valid` produce matching gaps in writes.
- Final beat accepted in cycle t:
  - FLUSH in t+1, carrying the last write.
  - `done` in t+2.
  - `busy` falls at t+3.
- Minimum tile time: `start` at cycle 0, LOAD from cycle 1, `done` at cycle N*N+2.
- `busy` rises the cycle after the accepted `start`.
- Reset values: `busy`=0, `done`=0, `err`=0, `s_ready`=0, `enA`=0, `weA`=0, `addrA`=0, `dinA`=0.

## Test plan
- Row-major, N=4, DEPTH=32, base=0, data 1..16 back-to-back with `s_last` on the 16th -> `addrA` 0..15 in order, `dinA` 1..16, `done` 2 cycles after the last accept, `err`=0.
- Transpose, N=4, base=0, data 1..16 -> `addrA` sequence 0,4,8,12,1,5,…,15. A read-back of word 1 returns 5; word 4 returns 2.
- Wrap-around, N=4, DEPTH=32, base=28, row-major -> addresses 28..31, then 0..11.
- Early `s_last` on beat 5 (k=5) -> exactly 6 writes, `err`=1, `done` pulses. A new `start` clears `err`.
- Missing `s_last` on beat 15, plus random `s_valid` gaps -> 16 writes with matching gaps, `err`=1, `done` pulses.
- `rst` asserted mid-LOAD after 7 beats -> next cycle all outputs are 0 and state is IDLE, the 7 words remain in the buffer, no `done`. `start` during LOAD is shown to be ignored.
